qlal3_a2f_reg_bridge: RTL

Fabric-side responder for the ASSPL SPI-to-fabric (A2F) bus. It sits directly downstream of the SPI cell's A2F master outputs and answers each `A2F_REQ` with `A2F_ACK` and read data. It implements a configurable control register bank, a 4-deep command FIFO drained by user logic, and a live status word returned to the ASSP. This gives an external SPI host register-level control of the user design.

---
 rtl/qlal3_a2f_reg_bridge_if.sv | 21 ++
 rtl/qlal3_a2f_reg_bridge.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/qlal3_a2f_reg_bridge_if.sv
// A2F bus between the ASSPL SPI cell (master) and the fabric-side register bridge (slave).
// Signal names follow the SPI cell's A2F port names.
interface qlal3_a2f_reg_bridge_if;
  logic       A2F_REQ;
  logic       A2F_RWn;
  logic [7:0] A2F_ADDR;
  logic [7:0] A2F_WR_DATA;
  logic       A2F_ACK;
  logic [7:0] A2F_RD_DATA;
  logic [6:0] A2F_Status;

  modport master (
    output A2F_REQ, A2F_RWn, A2F_ADDR, A2F_WR_DATA,
    input  A2F_ACK, A2F_RD_DATA, A2F_Status
  );

  modport slave (
    input  A2F_REQ, A2F_RWn, A2F_ADDR, A2F_WR_DATA,
    output A2F_ACK, A2F_RD_DATA, A2F_Status
  );
endinterface

// File: rtl/qlal3_a2f_reg_bridge.sv
// Fabric-side A2F responder: control register bank, 4-deep command FIFO and live status word.
// Define QLAL3_A2F_REQ_SYNC_EN to pass A2F_REQ through a two-flop synchronizer.
module qlal3_a2f_reg_bridge #(
  parameter int NUM_REGS = 16
) (
  input  logic                    SYSCLK,
  input  logic                    RESET_n,
  qlal3_a2f_reg_bridge_if.slave   a2f,
  output logic [8*NUM_REGS-1:0]   cfg_regs,
  input  logic                    fifo_rd_en,
  output logic [7:0]              fifo_dout,
  output logic                    fifo_empty
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACKED  = 2'd2
  } state_t;

  state_t               state_q;
  logic                 ack_q;
  logic [7:0]           rdData_q;
  logic [8*NUM_REGS-1:0] cfg_q;
  logic [7:0]           fifoMem_q [4];
  logic [1:0]           wrPtr_q;
  logic [1:0]           rdPtr_q;
  logic [2:0]           level_q;
  logic [2:0]           level_d;
  logic                 ovf_q;
  logic                 ovf_d;
  logic                 reqSampled;
  logic                 isWrite;
  logic                 fifoPush;
  logic                 ovfClear;
  logic                 fifoFull;
  logic                 fifoEmptyInt;
  logic                 doPush;
  logic                 doPop;
  logic [7:0]           rdMux;

`ifdef QLAL3_A2F_REQ_SYNC_EN
  logic [1:0] reqSync_q;

  always_ff @(posedge SYSCLK or negedge RESET_n) begin
    if (!RESET_n) reqSync_q <= 2'b00;
    else          reqSync_q <= {reqSync_q[0], a2f.A2F_REQ};
  end

  assign reqSampled = reqSync_q[1];
`else
  assign reqSampled = a2f.A2F_REQ;
`endif

  assign isWrite  = (state_q == ACCESS) && !a2f.A2F_RWn;
  assign fifoPush = isWrite && (a2f.A2F_ADDR == 8'hF0);
  assign ovfClear = isWrite && (a2f.A2F_ADDR == 8'hF2) && a2f.A2F_WR_DATA[0];

  assign fifoFull     = (level_q == 3'd4);
  assign fifoEmptyInt = (level_q == 3'd0);
  // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts it.
  assign doPop  = fifo_rd_en && !fifoEmptyInt;
  assign doPush = fifoPush && (!fifoFull || doPop);

  always_comb begin
    rdMux = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (a2f.A2F_ADDR == 8'(k)) rdMux = cfg_q[8*k +: 8];
    end
    case (a2f.A2F_ADDR)
      8'hF1:   rdMux = {5'b0, level_q};
      8'hF2:   rdMux = {7'b0, ovf_q};
      default: ;
    endcase
  end

  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q;
    if (doPush && !doPop)      level_d = level_q + 3'd1;
    else if (!doPush && doPop) level_d = level_q - 3'd1;
    if (fifoPush && !doPush)   ovf_d = 1'b1;
    else if (ovfClear)         ovf_d = 1'b0;
  end

  always_ff @(posedge SYSCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      rdData_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (reqSampled) state_q <= ACCESS;
        end
        ACCESS: begin
          state_q <= ACKED;
          ack_q   <= 1'b1;
          if (a2f.A2F_RWn) rdData_q <= rdMux;
        end
        ACKED: begin
          if (!reqSampled) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cfg_q <= '0;
    end else if (isWrite) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (a2f.A2F_ADDR == 8'(k)) cfg_q[8*k +: 8] <= a2f.A2F_WR_DATA;
      end
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wrPtr_q <= 2'd0;
      rdPtr_q <= 2'd0;
      level_q <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 2'd1;
      if (doPop)  rdPtr_q <= rdPtr_q + 2'd1;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: the head is only meaningful while the FIFO is non-empty.
  always_ff @(posedge SYSCLK) begin
    if (doPush) fifoMem_q[wrPtr_q] <= a2f.A2F_WR_DATA;
  end

  assign cfg_regs        = cfg_q;
  assign fifo_dout       = fifoMem_q[rdPtr_q];
  assign fifo_empty      = fifoEmptyInt;
  assign a2f.A2F_ACK     = ack_q;
  assign a2f.A2F_RD_DATA = rdData_q;
  assign a2f.A2F_Status  = {(state_q != IDLE), level_q, ovf_q, fifoFull, fifoEmptyInt};

endmodule
